// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the program counter and the IF/ID pipeline
// register, sequences BOOT/RUN/HALT, and applies branch/jump redirects,
// stalls and halt detection. PostPc carries PC+1 of the instruction in ID
// for the ID-stage branch-target adder.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] outAddId,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] PostPc,
    output logic [31:0] instr_id,
    output logic        id_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] post_pc_r;
    logic [31:0] instr_r;
    logic        valid_r;
    logic        halted_r;
    logic [31:0] pc_inc_s;

    // Sequential PC increment; wraps modulo 2^32 with no flag.
    assign pc_inc_s = pc_r + 32'd1;

    // Fetch state machine: PC, IF/ID register and halt flag updated together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_BOOT;
            pc_r      <= RESET_PC;
            post_pc_r <= 32'd0;
            instr_r   <= 32'd0;
            valid_r   <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    // One settling cycle: controls ignored, PC held.
                    state_r   <= ST_RUN;
                    pc_r      <= pc_r;
                    post_pc_r <= 32'd0;
                    instr_r   <= 32'd0;
                    valid_r   <= 1'b0;
                    halted_r  <= 1'b0;
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        // Branch beats both jump and stall.
                        state_r   <= ST_RUN;
                        pc_r      <= outAddId;
                        post_pc_r <= 32'd0;
                        instr_r   <= 32'd0;
                        valid_r   <= 1'b0;
                        halted_r  <= 1'b0;
                    end else if (jump_taken) begin
                        state_r   <= ST_RUN;
                        pc_r      <= jump_target;
                        post_pc_r <= 32'd0;
                        instr_r   <= 32'd0;
                        valid_r   <= 1'b0;
                        halted_r  <= 1'b0;
                    end else if (stall) begin
                        state_r   <= ST_RUN;
                        pc_r      <= pc_r;
                        post_pc_r <= post_pc_r;
                        instr_r   <= instr_r;
                        valid_r   <= valid_r;
                        halted_r  <= 1'b0;
                    end else if (imem_data == HALT_INSTR) begin
                        // PC stays on the halt word's address.
                        state_r   <= ST_HALT;
                        pc_r      <= pc_r;
                        post_pc_r <= 32'd0;
                        instr_r   <= 32'd0;
                        valid_r   <= 1'b0;
                        halted_r  <= 1'b1;
                    end else begin
                        state_r   <= ST_RUN;
                        pc_r      <= pc_inc_s;
                        post_pc_r <= pc_inc_s;
                        instr_r   <= imem_data;
                        valid_r   <= 1'b1;
                        halted_r  <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Terminal until reset; all controls ignored.
                    state_r   <= ST_HALT;
                    pc_r      <= pc_r;
                    post_pc_r <= 32'd0;
                    instr_r   <= 32'd0;
                    valid_r   <= 1'b0;
                    halted_r  <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: recover through BOOT.
                    state_r   <= ST_BOOT;
                    pc_r      <= pc_r;
                    post_pc_r <= 32'd0;
                    instr_r   <= 32'd0;
                    valid_r   <= 1'b0;
                    halted_r  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc_r;
    assign PostPc    = post_pc_r;
    assign instr_id  = instr_r;
    assign id_valid  = valid_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit. Each scenario plans a list of
// (stimulus, expected-output) pairs; expectations go onto a scoreboard queue
// and are popped and compared after each rising edge.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0010;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] post;
        logic [31:0] instr;
        logic        valid;
        logic        halt;
    } exp_t;

    typedef struct packed {
        logic        st;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
    } stim_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] outAddId;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] PostPc;
    logic [31:0] instr_id;
    logic        id_valid;
    logic        halted;

    logic        halt_en;
    logic [31:0] halt_addr;

    int checks;
    int errors;

    exp_t  sb_q[$];
    stim_t stim_q[$];

    fetch_pc_unit #(
        .RESET_PC  (RST_PC),
        .HALT_INSTR(32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch_taken(branch_taken),
        .outAddId    (outAddId),
        .jump_taken  (jump_taken),
        .jump_target (jump_target),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .PostPc      (PostPc),
        .instr_id    (instr_id),
        .id_valid    (id_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: never returns all-ones except at the planted halt address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {8'h5A, a[23:0]};
    endfunction

    assign imem_data = (halt_en && (imem_addr == halt_addr)) ? 32'hFFFF_FFFF : mem(imem_addr);

    function automatic exp_t bub(input logic [31:0] a);
        return '{addr: a, post: 32'd0, instr: 32'd0, valid: 1'b0, halt: 1'b0};
    endfunction

    // pc now a, ID holds the instruction fetched from p.
    function automatic exp_t vld(input logic [31:0] a, input logic [31:0] p);
        return '{addr: a, post: p + 32'd1, instr: mem(p), valid: 1'b1, halt: 1'b0};
    endfunction

    function automatic exp_t hlt(input logic [31:0] a);
        return '{addr: a, post: 32'd0, instr: 32'd0, valid: 1'b0, halt: 1'b1};
    endfunction

    function automatic stim_t sx(input logic st, input logic br, input logic [31:0] bt,
                                 input logic jp, input logic [31:0] jt);
        return '{st: st, br: br, bt: bt, jp: jp, jt: jt};
    endfunction

    function automatic stim_t sn();
        return sx(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endfunction

    function automatic exp_t observe();
        return '{addr: imem_addr, post: PostPc, instr: instr_id, valid: id_valid, halt: halted};
    endfunction

    function automatic void plan(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        sb_q.push_back(e);
    endfunction

    task automatic apply(input stim_t s);
        stall        = s.st;
        branch_taken = s.br;
        outAddId     = s.bt;
        jump_taken   = s.jp;
        jump_target  = s.jt;
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset = 1'b1;
        stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
        outAddId = 32'd0; jump_target = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t o, e;
        reset = 1'b1;
        stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
        outAddId = 32'd0; jump_target = 32'd0;
        @(posedge clk);
        #1;
        o = observe();
        e = bub(RST_PC);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_state got %h want %h", o, e);
        end
        reset = 1'b0;
        plan(sx(1'b0, 1'b1, 32'h99, 1'b1, 32'h77), bub(32'h10));
        plan(sn(), vld(32'h11, 32'h10));
        plan(sn(), vld(32'h12, 32'h11));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            o = observe();
            e = sb_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL boot got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_branch();
        exp_t o, e;
        restart();
        plan(sn(), bub(32'h10));
        plan(sx(1'b0, 1'b0, 32'd0, 1'b1, 32'h14), bub(32'h14));
        plan(sx(1'b0, 1'b1, 32'h40, 1'b0, 32'd0), bub(32'h40));
        plan(sn(), vld(32'h41, 32'h40));
        plan(sn(), vld(32'h42, 32'h41));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            o = observe();
            e = sb_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_stall_collisions();
        exp_t o, e;
        restart();
        plan(sn(), bub(32'h10));
        plan(sx(1'b0, 1'b0, 32'd0, 1'b1, 32'h1F), bub(32'h1F));
        plan(sn(), vld(32'h20, 32'h1F));
        for (int i = 0; i < 3; i++) plan(sx(1'b1, 1'b0, 32'd0, 1'b0, 32'd0), vld(32'h20, 32'h1F));
        plan(sn(), vld(32'h21, 32'h20));
        plan(sx(1'b1, 1'b1, 32'h80, 1'b0, 32'd0), bub(32'h80));
        plan(sn(), vld(32'h81, 32'h80));
        plan(sx(1'b0, 1'b1, 32'h90, 1'b1, 32'hA0), bub(32'h90));
        plan(sn(), vld(32'h91, 32'h90));
        plan(sx(1'b1, 1'b0, 32'd0, 1'b1, 32'hB0), bub(32'hB0));
        plan(sn(), vld(32'hB1, 32'hB0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            o = observe();
            e = sb_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_collide got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_halt();
        exp_t o, e;
        halt_addr = 32'h30;
        halt_en   = 1'b1;
        restart();
        plan(sn(), bub(32'h10));
        plan(sx(1'b0, 1'b0, 32'd0, 1'b1, 32'h2F), bub(32'h2F));
        plan(sn(), vld(32'h30, 32'h2F));
        plan(sx(1'b1, 1'b0, 32'd0, 1'b0, 32'd0), vld(32'h30, 32'h2F));
        plan(sn(), hlt(32'h30));
        plan(sx(1'b0, 1'b1, 32'h50, 1'b0, 32'd0), hlt(32'h30));
        plan(sx(1'b1, 1'b0, 32'd0, 1'b0, 32'd0), hlt(32'h30));
        plan(sx(1'b0, 1'b0, 32'd0, 1'b1, 32'h60), hlt(32'h30));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            o = observe();
            e = sb_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL halt got %h want %h", o, e);
            end
        end
        // Asynchronous reset out of HALT, mid-cycle.
        #3;
        reset = 1'b1;
        #1;
        o = observe();
        e = bub(RST_PC);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL halt_async_reset got %h want %h", o, e);
        end
        #1;
        reset   = 1'b0;
        halt_en = 1'b0;
    endtask

    task automatic test_wrap_async_reset();
        exp_t o, e;
        restart();
        plan(sn(), bub(32'h10));
        plan(sx(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF), bub(32'hFFFF_FFFF));
        plan(sn(), vld(32'h0, 32'hFFFF_FFFF));
        plan(sn(), vld(32'h1, 32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            o = observe();
            e = sb_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap got %h want %h", o, e);
            end
        end
        // Reset mid-cycle during RUN: outputs clear before the next edge.
        #3;
        reset = 1'b1;
        #1;
        o = observe();
        e = bub(RST_PC);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL run_async_reset got %h want %h", o, e);
        end
        #1;
        reset = 1'b0;
        plan(sn(), bub(32'h10));
        plan(sn(), vld(32'h11, 32'h10));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            o = observe();
            e = sb_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset_boot got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        halt_en   = 1'b0;
        halt_addr = 32'hDEAD_0000;
        reset     = 1'b1;
        stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
        outAddId = 32'd0; jump_target = 32'd0;
        test_reset();
        test_branch();
        test_stall_collisions();
        test_halt();
        test_wrap_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

- Instruction-fetch stage of the pipeline.
- Owns the program counter and the IF/ID pipeline register.
- Produces the registered `PostPc` (PC+1, word-addressed) consumed by the ID-stage branch-target adder.
- Consumes that adder's result as the branch target when the ID stage resolves a taken branch.
- Handles stall, flush, boot and halt sequencing.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `HALT_INSTR`, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `stall`  input  1  hazard unit request: hold PC and IF/ID.
- `branch_taken`  input  1  ID stage resolved a taken branch this cycle.
- `outAddId`  input  32  branch target from ID-stage adder.
- `jump_taken`  input  1  ID stage decoded an unconditional jump.
- `jump_target`  input  32  jump destination.
- `imem_data`  input  32  instruction word; combinational read of `imem_addr`.
- `imem_addr`  output  32  current PC; equal to the `pc` register.
- `PostPc`  output  32  IF/ID-registered PC+1 of the instruction in ID.
- `instr_id`  output  32  IF/ID-registered instruction.
- `id_valid`  output  1  IF/ID holds a real instruction; 0 means bubble.
- `halted`  output  1  high while in HALT.

## Operation
- State machine: BOOT, RUN, HALT.
  - Reset forces BOOT.
  - BOOT -> RUN unconditionally after one clock.
  - RUN -> HALT on a halt fetch (defined below).
  - HALT exits only via `reset`.
- Reset values:
  - `pc` = `RESET_PC`
  - `PostPc` = 0
  - `instr_id` = 0
  - `id_valid` = 0
  - `halted` = 0
- BOOT cycle:
  - PC holds.
  - IF/ID loads a bubble.
  - All control inputs are ignored.
- RUN priority per cycle, highest first:
  1. `branch_taken`: pc <= `outAddId`; IF/ID <= bubble.
  2. `jump_taken`: pc <= `jump_target`; IF/ID <= bubble.
  3. `stall`: pc and IF/ID hold unchanged.
  4. Halt fetch: `imem_data == HALT_INSTR` → state <= HALT; pc holds; IF/ID <= bubble.
  5. Normal: pc <= pc+1; `PostPc` <= pc+1; `instr_id` <= `imem_data`; `id_valid` <= 1.
- Bubble means `instr_id` = 0, `PostPc` = 0, `id_valid` = 0.
- `branch_taken` and `jump_taken` both high: branch wins, jump is dropped.
- Flush beats stall: the redirect is taken even when `stall` is high.
- HALT:
  - pc frozen at the halt instruction address.
  - IF/ID loads a bubble each cycle.
  - `halted` = 1.
  - All control inputs are ignored.
- Arithmetic:
  - PC increment is 32-bit modulo.
  - 32'hFFFF_FFFF + 1 wraps to 0 with no flag.
  - Targets are taken verbatim; no alignment check.

## Timing
- `imem_addr` changes only on clock edges or asynchronous reset. It is stable for the whole cycle.
- Fetch latency: instruction at PC p appears on `instr_id` with `PostPc` = p+1 one cycle after p is on `imem_addr`, provided no stall or flush.
- Redirect latency: `branch_taken` in cycle N → `imem_addr` = target in N+1, IF/ID is a bubble in N+1, and the target instruction reaches ID in N+2. Branch penalty is exactly one bubble.
- Stall of k cycles: `imem_addr`, `PostPc`, `instr_id` and `id_valid` are all unchanged for those k cycles. Advance resumes on the first cycle `stall` is low.
- `halted` rises the cycle after the halt word is sampled.
- Reset mid-operation: outputs take reset values immediately (asynchronous), regardless of state. The first valid `instr_id` appears 2 edges after `reset` falls: one BOOT edge, then one fetch edge.

## Test plan
- Reset/boot:
  - Stimulus: `RESET_PC`=0x10, release reset, memory returns sequential non-halt words.
  - Response: `imem_addr` 0x10, 0x10 (BOOT), 0x11, 0x12. First `id_valid`=1 with `PostPc`=0x11 on the 2nd edge.
- Taken branch:
  - Stimulus: `branch_taken`=1 with `outAddId`=0x40 while pc=0x14.
  - Response: next cycle pc=0x40 and `id_valid`=0. The following cycle `PostPc`=0x41.
- Stall plus branch/jump collisions:
  - Stimulus A: 3-cycle stall at pc=0x20.
  - Response A: all outputs frozen for 3 cycles, then pc 0x21.
  - Stimulus B: `stall`=1 together with `branch_taken`=1 (target 0x80).
  - Response B: pc=0x80 and a bubble.
  - Stimulus C: `branch_taken` and `jump_taken` both high.
  - Response C: `outAddId` is used.
- Halt:
  - Stimulus: `imem_data`=0xFFFF_FFFF at pc=0x30.
  - Response: `halted`=1 next cycle, pc stays 0x30, `id_valid`=0 thereafter. Later `branch_taken` and `stall` pulses have no effect.
- Wrap and async reset:
  - Stimulus A: jump to 0xFFFF_FFFF.
  - Response A: pc 0xFFFF_FFFF then 0x0, with `PostPc`=0x0.
  - Stimulus B: assert `reset` mid-cycle during RUN.
  - Response B: pc=`RESET_PC` and `id_valid`=0 before the next edge.
